// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program-counter unit.
package pc_pkg;

    // Source chosen for the next PC value.
    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_JMP,
        SEL_RET,
        SEL_HOLD
    } next_sel_e;

    localparam int unsigned DEFAULT_RAS_DEPTH = 4;
    localparam int unsigned RAS_PTR_W         = $clog2(DEFAULT_RAS_DEPTH);

    // Pointer width for a stack of the given depth, never narrower than one bit.
    function automatic int unsigned rasPtrWidth(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer whose oldest entry is overwritten
// when a push arrives while full; popping an empty stack only raises a pulse.
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = DEFAULT_RAS_DEPTH
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] pushData_i,
    output logic [WIDTH-1:0] top_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int unsigned PTR_W = rasPtrWidth(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == FULL_COUNT);
    assign top_o       = mem_q[wrPtr_q - PTR_W'(1)];
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

    // Pointer/count update; a push wins if both requests ever arrive together.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (push_i) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
            if (full_o) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop_i) begin
            if (empty_o) begin
                underflow_d = 1'b1;
            end else begin
                wrPtr_d = wrPtr_q - PTR_W'(1);
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Control state; reset empties the stack, discarding its contents.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wrPtr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Entry storage; content is only meaningful below the count, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_i && !reset_i) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: next-PC selection, stall, post-reset hold
// cycle, limit-wrap guard and a return-address stack for call/return.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] INCR         = WIDTH'(4),
    parameter logic [WIDTH-1:0] PC_LIMIT     = WIDTH'(36),
    parameter int unsigned      RAS_DEPTH    = DEFAULT_RAS_DEPTH
) (
    input  logic             Clk_i,
    input  logic             Reset_i,
    input  logic             Stall_i,
    input  logic             BranchTaken_i,
    input  logic [WIDTH-1:0] BranchTarget_i,
    input  logic             Jump_i,
    input  logic [WIDTH-1:0] JumpTarget_i,
    input  logic             Call_i,
    input  logic             Ret_i,
    output logic [WIDTH-1:0] PC_o,
    output logic [WIDTH-1:0] PCPlus4_o,
    output logic             Valid_o,
    output logic             Wrapped_o,
    output logic             RasEmpty_o,
    output logic             RasFull_o,
    output logic             RasOverflow_o,
    output logic             RasUnderflow_o
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             hold_q;
    logic             valid_q;
    logic             wrapped_q, wrapped_d;
    logic [WIDTH-1:0] pcPlusIncr;
    logic [WIDTH-1:0] nextPc;
    logic [WIDTH-1:0] rasTop;
    logic             rasEmpty;
    logic             rasPush;
    logic             rasPop;
    next_sel_e        sel;

    assign pcPlusIncr = pc_q + INCR;
    assign PC_o       = pc_q;
    assign PCPlus4_o  = pcPlusIncr;
    assign Valid_o    = valid_q;
    assign Wrapped_o  = wrapped_q;
    assign RasEmpty_o = rasEmpty;

    // Priority select; the hold cycle and stalls both freeze the PC.
    always_comb begin
        sel = SEL_SEQ;
        if (hold_q || Stall_i) begin
            sel = SEL_HOLD;
        end else if (BranchTaken_i) begin
            sel = SEL_BR;
        end else if (Jump_i) begin
            sel = SEL_JMP;
        end else if (Ret_i && !rasEmpty) begin
            sel = SEL_RET;
        end
    end

    // A call pushes only when its jump wins; a return pops (or underflows)
    // only when nothing of higher priority is redirecting.
    always_comb begin
        rasPush = (sel == SEL_JMP) && Call_i;
        rasPop  = !hold_q && !Stall_i && !BranchTaken_i && !Jump_i && Ret_i;
    end

    // Next-PC mux followed by the limit guard, applied to every moving source.
    always_comb begin
        nextPc = pcPlusIncr;
        case (sel)
            SEL_BR:   nextPc = BranchTarget_i;
            SEL_JMP:  nextPc = JumpTarget_i;
            SEL_RET:  nextPc = rasTop;
            SEL_HOLD: nextPc = pc_q;
            default:  nextPc = pcPlusIncr;
        endcase
        wrapped_d = (sel != SEL_HOLD) && (nextPc > PC_LIMIT);
        pc_d      = wrapped_d ? RESET_VECTOR : nextPc;
    end

    // PC register, post-reset hold flag, valid flag and wrap pulse.
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            pc_q      <= RESET_VECTOR;
            hold_q    <= 1'b1;
            valid_q   <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            hold_q    <= 1'b0;
            valid_q   <= 1'b1;
            wrapped_q <= wrapped_d;
        end
    end

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i       (Clk_i),
        .reset_i     (Reset_i),
        .push_i      (rasPush),
        .pop_i       (rasPop),
        .pushData_i  (pcPlusIncr),
        .top_o       (rasTop),
        .empty_o     (rasEmpty),
        .full_o      (RasFull_o),
        .overflow_o  (RasOverflow_o),
        .underflow_o (RasUnderflow_o)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues the state expected after
// each edge, an independent monitor pops and compares one entry per cycle.
module tb_pc_sequencer;

    // Expected post-edge state: flags = {valid, wrapped, empty, full, ovf, unf}.
    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [5:0]  flags;
    } exp_t;

    // Control bits: {reset, stall, branch, jump, call, ret}.
    localparam logic [5:0] C_NONE      = 6'b000000;
    localparam logic [5:0] C_RST       = 6'b100000;
    localparam logic [5:0] C_STALL_BR  = 6'b011000;
    localparam logic [5:0] C_STALL_RET = 6'b010001;
    localparam logic [5:0] C_BR        = 6'b001000;
    localparam logic [5:0] C_BR_JMP    = 6'b001100;
    localparam logic [5:0] C_BR_RET    = 6'b001001;
    localparam logic [5:0] C_BR_JC     = 6'b001110;
    localparam logic [5:0] C_JMP       = 6'b000100;
    localparam logic [5:0] C_JC        = 6'b000110;
    localparam logic [5:0] C_JCR       = 6'b000111;
    localparam logic [5:0] C_RET       = 6'b000001;

    localparam logic [5:0] F_RST  = 6'b001000;
    localparam logic [5:0] F_RUN  = 6'b101000;
    localparam logic [5:0] F_RAS  = 6'b100000;
    localparam logic [5:0] F_WRAP = 6'b111000;
    localparam logic [5:0] F_FULL = 6'b100100;
    localparam logic [5:0] F_OVF  = 6'b100110;
    localparam logic [5:0] F_UNF  = 6'b101001;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        jump;
    logic [31:0] jumpTarget;
    logic        call;
    logic        ret;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        valid;
    logic        wrapped;
    logic        rasEmpty;
    logic        rasFull;
    logic        rasOverflow;
    logic        rasUnderflow;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;

    pc_sequencer dut (
        .Clk_i          (clk),
        .Reset_i        (reset),
        .Stall_i        (stall),
        .BranchTaken_i  (branchTaken),
        .BranchTarget_i (branchTarget),
        .Jump_i         (jump),
        .JumpTarget_i   (jumpTarget),
        .Call_i         (call),
        .Ret_i          (ret),
        .PC_o           (pc),
        .PCPlus4_o      (pcPlus4),
        .Valid_o        (valid),
        .Wrapped_o      (wrapped),
        .RasEmpty_o     (rasEmpty),
        .RasFull_o      (rasFull),
        .RasOverflow_o  (rasOverflow),
        .RasUnderflow_o (rasUnderflow)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs on the falling edge and queue the expected result.
    task automatic applyStimulus(input string name, input logic [5:0] ctrl,
                                 input logic [31:0] brT, input logic [31:0] jT,
                                 input logic [31:0] expPc, input logic [5:0] expFlags);
        exp_t e;
        @(negedge clk);
        {reset, stall, branchTaken, jump, call, ret} = ctrl;
        branchTarget = brT;
        jumpTarget   = jT;
        e.name  = name;
        e.pc    = expPc;
        e.flags = expFlags;
        expQ.push_back(e);
    endtask

    // Compare the DUT's present outputs against one scoreboard entry.
    task automatic checkOutput(input exp_t e);
        logic [31:0] expPlus4;
        logic [5:0]  actFlags;
        expPlus4 = e.pc + 32'd4;
        actFlags = {valid, wrapped, rasEmpty, rasFull, rasOverflow, rasUnderflow};
        compared++;
        if (pc !== e.pc || pcPlus4 !== expPlus4 || actFlags !== e.flags) begin
            mismatched++;
            $display("[TB] FAIL %s: got pc=%0d pc+4=%0d flags=%b, expected pc=%0d pc+4=%0d flags=%b",
                     e.name, pc, pcPlus4, actFlags, e.pc, expPlus4, e.flags);
        end
    endtask

    // Monitor: one entry per rising edge, sampled shortly after the edge.
    always @(posedge clk) begin
        #1;
        if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front());
        end
    end

    initial begin
        {reset, stall, branchTaken, jump, call, ret} = C_RST;
        branchTarget = '0;
        jumpTarget   = '0;

        // Reset for two cycles, hold cycle, then sequential fetch.
        applyStimulus("reset1",  C_RST,  0, 0, 0, F_RST);
        applyStimulus("reset2",  C_RST,  0, 0, 0, F_RST);
        applyStimulus("hold",    C_NONE, 0, 0, 0, F_RUN);
        applyStimulus("seq4",    C_NONE, 0, 0, 4, F_RUN);
        applyStimulus("seq8",    C_NONE, 0, 0, 8, F_RUN);

        // Sequential run up to the limit and wrap.
        for (int p = 12; p <= 36; p += 4) begin
            applyStimulus("seqRun", C_NONE, 0, 0, p, F_RUN);
        end
        applyStimulus("limitWrap", C_NONE, 0, 0, 0, F_WRAP);
        applyStimulus("afterWrap", C_NONE, 0, 0, 4, F_RUN);
        applyStimulus("toEight",   C_NONE, 0, 0, 8, F_RUN);

        // Branch beats jump; stall drops a branch; branch beyond limit wraps.
        applyStimulus("brOverJmp", C_BR_JMP,   20, 28, 20, F_RUN);
        applyStimulus("stallBr",   C_STALL_BR,  4,  0, 20, F_RUN);
        applyStimulus("postStall", C_NONE,      0,  0, 24, F_RUN);
        applyStimulus("brWrap",    C_BR,       40,  0,  0, F_WRAP);
        applyStimulus("brWrapSeq", C_NONE,      0,  0,  4, F_RUN);

        // Call and return, then return on an empty stack.
        applyStimulus("call24",    C_JC,  0, 24, 24, F_RAS);
        applyStimulus("ret8",      C_RET, 0,  0,  8, F_RUN);
        applyStimulus("retUnder",  C_RET, 0,  0, 12, F_UNF);
        applyStimulus("seq16",     C_NONE, 0, 0, 16, F_RUN);

        // Fill the stack, overflow it, then drain and underflow.
        applyStimulus("brZero",    C_BR,  0,  0,  0, F_RUN);
        applyStimulus("push1",     C_JC,  0,  4,  4, F_RAS);
        applyStimulus("push2",     C_JC,  0,  8,  8, F_RAS);
        applyStimulus("push3",     C_JC,  0, 12, 12, F_RAS);
        applyStimulus("push4Full", C_JC,  0, 16, 16, F_FULL);
        applyStimulus("push5Ovf",  C_JC,  0, 20, 20, F_OVF);
        applyStimulus("pop20",     C_RET, 0,  0, 20, F_RAS);
        applyStimulus("pop16",     C_RET, 0,  0, 16, F_RAS);
        applyStimulus("pop12",     C_RET, 0,  0, 12, F_RAS);
        applyStimulus("pop8",      C_RET, 0,  0,  8, F_RUN);
        applyStimulus("pop5Under", C_RET, 0,  0, 12, F_UNF);

        // Combined controls and a return address beyond the limit.
        applyStimulus("jmpCallRet",  C_JCR,       0, 28, 28, F_RAS);
        applyStimulus("brBeatsRet",  C_BR_RET,    0,  0,  0, F_RAS);
        applyStimulus("ret16",       C_RET,       0,  0, 16, F_RUN);
        applyStimulus("brCallNoPush",C_BR_JC,     8, 24,  8, F_RUN);
        applyStimulus("stallRet",    C_STALL_RET, 0,  0,  8, F_RUN);
        applyStimulus("jmp36",       C_JMP,       0, 36, 36, F_RUN);
        applyStimulus("call40",      C_JC,        0,  0,  0, F_RAS);
        applyStimulus("retWrap",     C_RET,       0,  0,  0, F_WRAP);
        applyStimulus("retWrapSeq",  C_NONE,      0,  0,  4, F_RUN);

        // Reset in the middle of a call sequence discards the stack.
        applyStimulus("push8",       C_JC,  0, 20, 20, F_RAS);
        applyStimulus("midReset",    C_RST, 0,  0,  0, F_RST);
        applyStimulus("holdIgnRet",  C_RET, 0,  0,  0, F_RUN);
        applyStimulus("retAfterRst", C_RET, 0,  0,  4, F_UNF);
        applyStimulus("finalSeq",    C_NONE, 0, 0,  8, F_RUN);

        // Let the monitor drain the scoreboard, with a bounded wait.
        for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (expQ.size() > 0) begin
            mismatched++;
            $display("[TB] FAIL drain: got %0d pending entries, expected 0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
